// File: rtl/mbr_fetch_queue.sv
// Prefetching instruction byte queue: fills a DEPTH-byte ring from word-wide memory
// reads and presents the head byte/halfword (MBR1/MBR2) and an extended A-bus value.
module mbr_fetch_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         fetch_req,
    output logic [31:0]                  fetch_addr,
    input  logic                         mem_valid,
    input  logic [8*FETCH_BYTES-1:0]     mem_data,
    input  logic                         pc_load,
    input  logic [31:0]                  pc_in,
    input  logic                         consume1,
    input  logic                         consume2,
    input  logic                         ena_a,
    input  logic                         size2,
    input  logic                         to_signed,
    output logic [7:0]                   mbr1,
    output logic [15:0]                  mbr2,
    output logic                         mbr1_ok,
    output logic                         mbr2_ok,
    output logic [7:0]                   mbr2mpc,
    output logic [31:0]                  a_bus,
    output logic [31:0]                  pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = $clog2(FETCH_BYTES);

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head1;
    logic          pending;
    logic          discard;
    logic [SW-1:0] skip;

    logic          accept;
    logic [CW-1:0] n_written;
    logic [1:0]    pop;

    // Pointer advance modulo DEPTH; n is always below DEPTH.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Write acceptance, pop size and request decision for this cycle.
    always_comb begin
        accept    = mem_valid && pending && !discard && !pc_load;
        n_written = accept ? CW'(FETCH_BYTES - 32'(skip)) : '0;
        pop       = 2'd0;
        if (consume2 && count >= CW'(2))
            pop = 2'd2;
        else if (consume1 && count >= CW'(1))
            pop = 2'd1;
        fetch_req = !reset && !pending && !pc_load && ((32'(count) + FETCH_BYTES) <= DEPTH);
    end

    // Queue storage; bytes below skip belong to addresses before the redirect target.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
                if (k >= 32'(skip))
                    buf_q[wrap_add(tail, k - 32'(skip))] <= mem_data[8*k +: 8];
            end
        end
    end

    // Control state: pointers, count, pc and the single outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pc         <= '0;
            fetch_addr <= '0;
            pending    <= 1'b0;
            discard    <= 1'b0;
            skip       <= '0;
        end else if (pc_load) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pc         <= pc_in;
            fetch_addr <= {pc_in[31:SW], SW'(0)};
            skip       <= pc_in[SW-1:0];
            // A response landing in the redirect cycle retires the old request itself.
            if (pending) begin
                if (mem_valid) begin
                    pending <= 1'b0;
                    discard <= 1'b0;
                end else begin
                    discard <= 1'b1;
                end
            end
        end else begin
            head  <= wrap_add(head, 32'(pop));
            tail  <= wrap_add(tail, 32'(n_written));
            count <= count + n_written - CW'(pop);
            pc    <= pc + 32'(pop);
            if (mem_valid && pending) begin
                pending <= 1'b0;
                discard <= 1'b0;
                if (!discard) skip <= '0;
            end
            if (fetch_req) begin
                pending    <= 1'b1;
                fetch_addr <= fetch_addr + 32'(FETCH_BYTES);
            end
        end
    end

    // Head byte/halfword views and the OR-mux A-bus driver.
    always_comb begin
        head1   = wrap_add(head, 1);
        mbr1_ok = (count >= CW'(1));
        mbr2_ok = (count >= CW'(2));
        mbr1    = mbr1_ok ? buf_q[head] : 8'h00;
        mbr2    = mbr2_ok ? {buf_q[head], buf_q[head1]} : 16'h0000;
        mbr2mpc = mbr1;
        a_bus   = 32'h0;
        if (ena_a) begin
            if (size2)
                a_bus = {{16{to_signed & mbr2[15]}}, mbr2};
            else
                a_bus = {{24{to_signed & mbr1[7]}}, mbr1};
        end
    end

endmodule

// File: tb/tb_mbr_fetch_queue.sv
// Bench for mbr_fetch_queue: directed scenarios plus a randomized run against a byte-queue model.
module tb_mbr_fetch_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FB    = 4;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        mem_valid;
    logic [8*FB-1:0] mem_data;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        consume1, consume2, ena_a, size2, to_signed;
    logic [7:0]  mbr1;
    logic [15:0] mbr2;
    logic        mbr1_ok, mbr2_ok;
    logic [7:0]  mbr2mpc;
    logic [31:0] a_bus;
    logic [31:0] pc;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [7:0]  q[$];
    logic [31:0] m_pc, m_faddr;
    bit          m_pending, m_discard;
    int          m_skip;

    mbr_fetch_queue #(.DEPTH(DEPTH), .FETCH_BYTES(FB)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .mem_valid(mem_valid), .mem_data(mem_data), .pc_load(pc_load), .pc_in(pc_in),
        .consume1(consume1), .consume2(consume2), .ena_a(ena_a), .size2(size2),
        .to_signed(to_signed), .mbr1(mbr1), .mbr2(mbr2), .mbr1_ok(mbr1_ok),
        .mbr2_ok(mbr2_ok), .mbr2mpc(mbr2mpc), .a_bus(a_bus), .pc(pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return 8'((a * 13) ^ (a >> 3) ^ 32'h5A);
    endfunction

    function automatic logic [8*FB-1:0] word_at(input logic [31:0] a);
        logic [8*FB-1:0] w;
        for (int k = 0; k < FB; k++) w[8*k +: 8] = mem_byte(a + 32'(k));
        return w;
    endfunction

    function automatic bit exp_req();
        return !reset && !m_pending && !pc_load && (q.size() + FB <= DEPTH);
    endfunction

    function automatic logic [7:0] exp_mbr1();
        return (q.size() >= 1) ? q[0] : 8'h00;
    endfunction

    function automatic logic [15:0] exp_mbr2();
        return (q.size() >= 2) ? {q[0], q[1]} : 16'h0000;
    endfunction

    function automatic logic [31:0] exp_abus();
        logic [31:0] v;
        if (!ena_a) return 32'h0;
        if (size2) begin
            v = 32'(exp_mbr2());
            if (to_signed && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = 32'(exp_mbr1());
            if (to_signed && v >= 32'h80) v = v + 32'hFFFFFF00;
        end
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit req;
        int npop;
        req = exp_req();
        if (reset) begin
            q.delete(); m_pc = 0; m_faddr = 0; m_pending = 0; m_discard = 0; m_skip = 0;
        end else if (pc_load) begin
            q.delete();
            m_pc    = pc_in;
            m_faddr = pc_in & ~32'(FB - 1);
            m_skip  = int'(pc_in % FB);
            if (m_pending) begin
                if (mem_valid) m_pending = 0;
                else m_discard = 1;
            end
        end else begin
            npop = 0;
            if (consume2 && q.size() >= 2) npop = 2;
            else if (consume1 && q.size() >= 1) npop = 1;
            repeat (npop) void'(q.pop_front());
            m_pc = m_pc + 32'(npop);
            if (mem_valid && m_pending) begin
                if (!m_discard) begin
                    for (int k = m_skip; k < FB; k++) q.push_back(mem_data[8*k +: 8]);
                    m_skip = 0;
                end
                m_pending = 0;
                m_discard = 0;
            end
            if (req) begin
                m_pending = 1;
                m_faddr   = m_faddr + 32'(FB);
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        mem_valid = 0; mem_data = '0; pc_load = 0; pc_in = 0;
        consume1 = 0; consume2 = 0; ena_a = 0; size2 = 0; to_signed = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        tick();
        ena_a = 1; size2 = 1; to_signed = 1;
        #1;
        total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", fetch_req); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        total++; if (fetch_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", fetch_addr); end
        total++; if ({mbr1, mbr2, mbr1_ok, mbr2_ok, mbr2mpc} !== 34'h0) begin bad++; $display("FAIL reset_mbr: got %h %h %b %b want zeros", mbr1, mbr2, mbr1_ok, mbr2_ok); end
        total++; if (a_bus !== 32'h0) begin bad++; $display("FAIL reset_abus: got %h want 0", a_bus); end
        reset = 0;
        #1;
        total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL reset_first_req: got %0b want 1", fetch_req); end
        idle();
    endtask

    task automatic test_fill();
        do_reset();
        #1;
        total++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin bad++; $display("FAIL fill_req0: got %0b@%h want 1@0", fetch_req, fetch_addr); end
        tick();
        mem_valid = 1; mem_data = 32'h44332211;
        #1;
        total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL fill_pending: got %0b want 0", fetch_req); end
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL fill_count4: got %0d want 4", count); end
        total++; if (mbr1 !== 8'h11 || mbr2 !== 16'h1122) begin bad++; $display("FAIL fill_mbr: got %h %h want 11 1122", mbr1, mbr2); end
        total++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h4) begin bad++; $display("FAIL fill_req4: got %0b@%h want 1@4", fetch_req, fetch_addr); end
        tick();
        mem_valid = 1; mem_data = 32'h88776655;
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count8: got %0d want 8", count); end
        total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL fill_full_req: got %0b want 0", fetch_req); end
        total++; if (mbr2 !== 16'h1122) begin bad++; $display("FAIL fill_full_mbr2: got %h want 1122", mbr2); end
    endtask

    task automatic test_ext();
        do_reset();
        tick();
        mem_valid = 1; mem_data = 32'h000080FF;
        tick();
        mem_valid = 0; ena_a = 1; size2 = 1; to_signed = 1;
        #1;
        total++; if (a_bus !== 32'hFFFFFF80) begin bad++; $display("FAIL ext_s16: got %h want ffffff80", a_bus); end
        to_signed = 0;
        #1;
        total++; if (a_bus !== 32'h0000FF80) begin bad++; $display("FAIL ext_z16: got %h want 0000ff80", a_bus); end
        consume1 = 1;
        tick();
        consume1 = 0; size2 = 0; to_signed = 1;
        #1;
        total++; if (a_bus !== 32'hFFFFFF80) begin bad++; $display("FAIL ext_s8: got %h want ffffff80", a_bus); end
        total++; if (mbr2mpc !== 8'h80) begin bad++; $display("FAIL ext_mpc: got %h want 80", mbr2mpc); end
        ena_a = 0;
        #1;
        total++; if (a_bus !== 32'h0) begin bad++; $display("FAIL ext_off: got %h want 0", a_bus); end
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        pc_load = 1; pc_in = 32'd6;
        #1;
        total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL redir_req_block: got %0b want 0", fetch_req); end
        tick();
        pc_load = 0; mem_valid = 1; mem_data = 32'h44332211;
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL redir_stale: got count %0d want 0", count); end
        total++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h4) begin bad++; $display("FAIL redir_req4: got %0b@%h want 1@4", fetch_req, fetch_addr); end
        tick();
        mem_valid = 1; mem_data = 32'hDDCCBBAA;
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd2 || mbr2 !== 16'hCCDD) begin bad++; $display("FAIL redir_data: got %0d %h want 2 ccdd", count, mbr2); end
        total++; if (pc !== 32'd6) begin bad++; $display("FAIL redir_pc: got %h want 6", pc); end
        total++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8) begin bad++; $display("FAIL redir_req8: got %0b@%h want 1@8", fetch_req, fetch_addr); end
    endtask

    task automatic test_underflow();
        do_reset();
        pc_load = 1; pc_in = 32'd3;
        tick();
        pc_load = 0;
        tick();
        mem_valid = 1; mem_data = 32'h44332211;
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd1 || mbr1 !== 8'h44 || pc !== 32'd3) begin bad++; $display("FAIL uf_setup: got %0d %h %h want 1 44 3", count, mbr1, pc); end
        total++; if (mbr2_ok !== 1'b0 || mbr1_ok !== 1'b1 || mbr2 !== 16'h0) begin bad++; $display("FAIL uf_ok: got %b %b %h want 1 0 0000", mbr1_ok, mbr2_ok, mbr2); end
        consume2 = 1;
        tick();
        consume2 = 0;
        #1;
        total++; if (count !== 4'd1 || pc !== 32'd3) begin bad++; $display("FAIL uf_c2: got %0d %h want 1 3", count, pc); end
        consume1 = 1;
        tick();
        #1;
        total++; if (count !== 4'd0 || pc !== 32'd4) begin bad++; $display("FAIL uf_c1: got %0d %h want 0 4", count, pc); end
        tick();
        consume1 = 0;
        #1;
        total++; if (count !== 4'd0 || pc !== 32'd4) begin bad++; $display("FAIL uf_empty: got %0d %h want 0 4", count, pc); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        tick();
        mem_valid = 1; mem_data = 32'h44332211;
        tick();
        mem_valid = 0;
        tick();
        mem_valid = 1; mem_data = 32'h88776655; consume2 = 1;
        #1;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL same_pre: got %0d want 4", count); end
        tick();
        idle();
        #1;
        total++; if (count !== 4'd6 || pc !== 32'd2) begin bad++; $display("FAIL same_post: got %0d %h want 6 2", count, pc); end
        total++; if (mbr1 !== 8'h33 || mbr2 !== 16'h3344) begin bad++; $display("FAIL same_head: got %h %h want 33 3344", mbr1, mbr2); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        tick();
        reset = 1;
        tick();
        reset = 0; mem_valid = 1; mem_data = 32'h44332211;
        #1;
        total++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin bad++; $display("FAIL rstp_req: got %0b@%h want 1@0", fetch_req, fetch_addr); end
        tick();
        mem_valid = 0;
        #1;
        total++; if (count !== 4'd0 || pc !== 32'd0) begin bad++; $display("FAIL rstp_ignore: got %0d %h want 0 0", count, pc); end
    endtask

    task automatic test_random();
        bit          busy;
        int          lat;
        logic [31:0] raddr;
        busy = 0; lat = 0; raddr = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            mem_valid = 0; mem_data = '0;
            if (busy && lat == 0) begin
                mem_valid = 1; mem_data = word_at(raddr); busy = 0;
            end else if (busy) begin
                lat--;
            end else if ($urandom_range(0, 19) == 0) begin
                mem_valid = 1; mem_data = $urandom;
            end
            consume1  = 1'($urandom_range(0, 1));
            consume2  = ($urandom_range(0, 3) == 0);
            pc_load   = ($urandom_range(0, 39) == 0);
            pc_in     = 32'($urandom_range(0, 255));
            ena_a     = 1'($urandom_range(0, 1));
            size2     = 1'($urandom_range(0, 1));
            to_signed = 1'($urandom_range(0, 1));
            #1;
            total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count, q.size()); end
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, pc, m_pc); end
            total++; if (mbr1 !== exp_mbr1() || mbr2mpc !== exp_mbr1()) begin bad++; $display("FAIL rnd_mbr1 c=%0d: got %h/%h want %h", c, mbr1, mbr2mpc, exp_mbr1()); end
            total++; if (mbr2 !== exp_mbr2()) begin bad++; $display("FAIL rnd_mbr2 c=%0d: got %h want %h", c, mbr2, exp_mbr2()); end
            total++; if (a_bus !== exp_abus()) begin bad++; $display("FAIL rnd_abus c=%0d: got %h want %h", c, a_bus, exp_abus()); end
            total++; if (fetch_req !== exp_req() || fetch_addr !== m_faddr) begin bad++; $display("FAIL rnd_fetch c=%0d: got %0b@%h want %0b@%h", c, fetch_req, fetch_addr, exp_req(), m_faddr); end
            if (q.size() >= 1) begin
                total++; if (mbr1 !== mem_byte(m_pc)) begin bad++; $display("FAIL rnd_order c=%0d: got %h want %h", c, mbr1, mem_byte(m_pc)); end
            end
            if (exp_req()) begin
                busy = 1; raddr = m_faddr; lat = $urandom_range(0, 2);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_fill();
        test_ext();
        test_redirect();
        test_underflow();
        test_same_cycle();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mbr_fetch_queue.md
# mbr_fetch_queue

Parametrised successor to the single-byte memory buffer register. It prefetches instruction bytes from main memory in FETCH_BYTES-wide words into a DEPTH-byte queue and tracks the byte PC. It presents the head byte (MBR1) and head halfword (MBR2, big-endian operand order) to the datapath. It drives the A bus with optional sign extension, or zero extension, to 32 bits. It sits between the memory port and the datapath/MPC logic, replacing the fetch-one-byte-per-request scheme.

## Interface
- DEPTH, 8: queue capacity in bytes; must be at least FETCH_BYTES+2.
- FETCH_BYTES, 4: bytes per memory read; must be a power of two and at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- fetch_req  out  1  read request for fetch_addr; a single-cycle pulse.
- fetch_addr  out  32  byte address; always FETCH_BYTES-aligned.
- mem_valid  in  1  mem_data valid this cycle.
- mem_data  in  8*FETCH_BYTES  read word; byte k (lowest address first) is mem_data[8k+7:8k].
- pc_load  in  1  redirect: flush the queue and restart at pc_in.
- pc_in  in  32  new byte PC.
- consume1  in  1  pop 1 byte.
- consume2  in  1  pop 2 bytes; wins over consume1.
- ena_a  in  1  drive a_bus.
- size2  in  1  a_bus source: MBR2 when 1, MBR1 when 0.
- to_signed  in  1  sign-extend when 1, zero-extend when 0.
- mbr1  out  8  head byte.
- mbr2  out  16  {head, head+1}.
- mbr1_ok / mbr2_ok  out  1 each  count≥1 / count≥2.
- mbr2mpc  out  8  equals mbr1.
- a_bus  out  32  extended value; all zeros when ena_a=0 (OR-mux bus, no tristate).
- pc  out  32  byte address of the head byte.
- count  out  $clog2(DEPTH+1)  bytes held.

## Operation
- Queue: a circular byte buffer with head/tail pointers that wrap modulo DEPTH, plus a byte count.
- fetch_req = !reset && !pending && !pc_load && (count+FETCH_BYTES ≤ DEPTH), evaluated on current count. Consumption in the same cycle is not credited.
- Issuing a request sets pending and advances fetch_addr by FETCH_BYTES at the edge.
- At most one request is outstanding. Memory latency is ≥1 cycle and variable.
- mem_valid while pending: the word is written. Bytes skip..FETCH_BYTES-1 go to the tail in address order. count grows by FETCH_BYTES−skip. skip then clears and pending clears.
- mem_valid while not pending: ignored.
- Overflow cannot occur, because of the space check and the single outstanding request.
- Consume:
  - consume2 with count≥2: pop 2 and pc+=2.
  - Otherwise consume1 with count≥1: pop 1 and pc+=1.
  - A consume without enough bytes is ignored; no state changes.
- A write and a consume in the same cycle are both applied: count_next = count + written − popped.
- pc_load (priority over all other actions):
  - count←0 and pointers←0.
  - pc←pc_in.
  - fetch_addr←pc_in with the low log2(FETCH_BYTES) bits cleared.
  - skip←pc_in mod FETCH_BYTES.
  - If pending is set, the discard flag is set; the next mem_valid is dropped and clears pending and discard.
  - mem_valid arriving in the pc_load cycle itself is dropped.
- Outputs:
  - mbr1 = count≥1 ? head : 0.
  - mbr2 = count≥2 ? {head, head+1} : 0.
  - a_bus = ena_a ? ext(size2 ? mbr2 : mbr1) : 0, where ext sign- or zero-extends per to_signed.

## Timing
- Reset values: every output 0; pc=0, fetch_addr=0, count=0, pending=0, discard=0, skip=0.
- fetch_req may assert in the first cycle after reset deasserts.
- fetch_req in cycle N, mem_valid in cycle M>N: bytes become visible on mbr1/mbr2/count in cycle M+1.
- Consume in cycle N: new head, pc and count are visible in cycle N+1.
- mbr*, a_bus, *_ok and fetch_req are combinational from registered state and the current inputs. No other output depends combinationally on inputs.
- Reset mid-operation clears pending and discard. A later mem_valid is ignored.

## Test plan
- Reset, then serve the request with addr 0 → mem_data=0x44332211: next cycle count=4, mbr1=0x11, mbr2=0x1122; second request at addr 4; after 0x88776655, count=8 and fetch_req stays 0.
- Head bytes 0xFF,0x80: size2=1, to_signed=1 → a_bus=0xFFFFFF80; to_signed=0 → 0x0000FF80. Then consume1 and size2=0, to_signed=1 → a_bus=0xFFFFFF80. ena_a=0 → a_bus=0.
- pc_load pc_in=6 while a request is pending: the stale mem_valid (0x44332211) is dropped; the next fetch is at addr 4; data 0xDDCCBBAA → count=2, mbr2=0xCCDD, pc=6; then a fetch at addr 8.
- Underflow: count=1 with consume2 → no change; consume1 → count=0, pc+1; consume1 at count=0 → ignored.
- count=4 with mem_valid and consume2 in the same cycle → count=6, pc+=2. Run 20 mixed consumes across pointer wrap → byte order matches the address sequence.
- Reset while pending, then mem_valid → count=0, pc=0; fetch_req=1 at addr 0 the cycle after reset deasserts.
